// File: rtl/ring_pkg.sv
// ring_pkg: defaults and shared types for the ring reader.
//   DEF_DATA_W   - sample width
//   DEF_ADDR_W   - ring address / index width
//   DEF_RAND_TMO - cycles to wait for ring_rand_valid before re-issuing
//   rd_state_t   - reader FSM state encoding
//   decode_len   - maps burst_len (0 means 128) to a beat count
package ring_pkg;
  localparam int unsigned DEF_DATA_W   = 14;
  localparam int unsigned DEF_ADDR_W   = 7;
  localparam int unsigned DEF_RAND_TMO = 6;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_RAND_REQ  = 2'd2,
    ST_RAND_WAIT = 2'd3
  } rd_state_t;

  // A zero burst length encodes the maximum burst of 128 samples.
  function automatic logic [CNT_W-1:0] decode_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(128) : len;
  endfunction
endpackage

// File: rtl/ring_out_slice.sv
// ring_out_slice: single-entry valid/ready output register for the stream.
//   clk, rst          - clock, synchronous active-high reset
//   load              - capture load_data/load_last (caller guarantees room)
//   load_data/last    - beat to capture
//   m_tready          - downstream accept
//   m_tdata/valid/last - registered stream outputs, held while stalled
module ring_out_slice
  import ring_pkg::*;
#(
  parameter int unsigned W = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast
);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tdata  <= load_data;
      m_tvalid <= 1'b1;
      m_tlast  <= load_last;
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_reader.sv
// ring_reader: streams bursts of samples from a ring front and services
// single random-read requests in between.
//   clk, rst                  - clock, synchronous active-high reset
//   ring_dout/ready/index     - ring front sample, valid, and its address
//   ring_rd_en                - pop ring front
//   ring_rand_addr/en/valid   - random-read request and data-valid
//   start, burst_len          - begin a burst (0 means 128 beats)
//   busy, done                - burst in progress / end-of-burst pulse
//   m_tdata/tvalid/tready/tlast - {index, sample} output stream
//   req_addr/valid/ready      - random-read request handshake
//   rsp_data/rsp_valid        - random-read response pulse
module ring_reader
  import ring_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RAND_TMO = DEF_RAND_TMO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        ring_dout,
  input  logic                     ring_ready,
  input  logic [ADDR_W-1:0]        ring_index,
  output logic                     ring_rd_en,
  output logic [ADDR_W-1:0]        ring_rand_addr,
  output logic                     ring_rand_en,
  input  logic                     ring_rand_valid,
  input  logic                     start,
  input  logic [7:0]               burst_len,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W+DATA_W-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_valid
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RAND_TMO - 1);

  rd_state_t        state_q, state_d;
  rd_state_t        ret_q, ret_d, ret_eff;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] beats_q;
  logic [CNT_W-1:0] tmo_q;
  logic             req_pending_q;
  logic             start_acc;
  logic             last_acc;
  logic             load_last;

  assign last_acc  = m_tvalid & m_tready & m_tlast;
  assign load_last = ((beats_q + CNT_W'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    ring_rd_en   = 1'b0;
    ring_rand_en = 1'b0;
    req_ready    = 1'b0;
    start_acc    = 1'b0;
    // The output slice keeps draining during a random read, so a burst can
    // finish there; the return target then collapses to IDLE.
    ret_eff      = last_acc ? ST_IDLE : ret_q;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          req_ready = ~req_pending_q;
          if (start) begin
            start_acc = 1'b1;
            state_d   = ST_STREAM;
          end else if (req_pending_q) begin
            state_d = ST_RAND_REQ;
            ret_d   = ST_IDLE;
          end
        end
        ST_STREAM: begin
          ring_rd_en = ring_ready & (~m_tvalid | m_tready) & (beats_q < len_q) & ~req_pending_q;
          req_ready  = ~ring_rd_en & ~req_pending_q;
          if (req_pending_q) begin
            state_d = ST_RAND_REQ;
            ret_d   = last_acc ? ST_IDLE : ST_STREAM;
          end else if (last_acc) begin
            state_d = ST_IDLE;
          end
        end
        ST_RAND_REQ: begin
          ring_rand_en = ring_ready;
          ret_d        = ret_eff;
          if (ring_ready) state_d = ST_RAND_WAIT;
        end
        ST_RAND_WAIT: begin
          ret_d = ret_eff;
          if (ring_rand_valid) state_d = ret_eff;
          else if (tmo_q == TMO_LAST) state_d = ST_RAND_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q          <= '0;
      beats_q        <= '0;
      tmo_q          <= '0;
      req_pending_q  <= 1'b0;
      ring_rand_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rsp_data       <= '0;
      rsp_valid      <= 1'b0;
    end else begin
      done      <= last_acc;
      rsp_valid <= 1'b0;
      // busy stays high through the done cycle and drops right after it.
      if (start_acc) begin
        len_q   <= decode_len(burst_len);
        beats_q <= '0;
        busy    <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (ring_rd_en) beats_q <= beats_q + CNT_W'(1);
      if (req_valid && req_ready) begin
        ring_rand_addr <= req_addr;
        req_pending_q  <= 1'b1;
      end
      if (ring_rand_en) tmo_q <= '0;
      else if (state_q == ST_RAND_WAIT) tmo_q <= tmo_q + CNT_W'(1);
      if (state_q == ST_RAND_WAIT && ring_rand_valid) begin
        rsp_data      <= ring_dout;
        rsp_valid     <= 1'b1;
        req_pending_q <= 1'b0;
      end
    end
  end

  ring_out_slice #(.W(ADDR_W + DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (ring_rd_en),
    .load_data ({ring_index, ring_dout}),
    .load_last (load_last),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast)
  );

endmodule

// File: tb/tb_ring_reader.sv
// Directed bench for ring_reader with a simple ring model.
module tb_ring_reader;
  import ring_pkg::*;

  localparam int unsigned DW  = DEF_DATA_W;
  localparam int unsigned AW  = DEF_ADDR_W;
  localparam int unsigned TMO = DEF_RAND_TMO;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]    ring_dout;
  logic             ring_ready;
  logic [AW-1:0]    ring_index;
  logic             ring_rd_en;
  logic [AW-1:0]    ring_rand_addr;
  logic             ring_rand_en;
  logic             ring_rand_valid = 1'b0;
  logic             start;
  logic [7:0]       burst_len;
  logic             busy, done;
  logic [AW+DW-1:0] m_tdata;
  logic             m_tvalid, m_tready, m_tlast;
  logic [AW-1:0]    req_addr;
  logic             req_valid, req_ready;
  logic [DW-1:0]    rsp_data;
  logic             rsp_valid;
  logic [2*AW+2*DW+7:0] all_out;

  assign all_out = {ring_rd_en, ring_rand_en, ring_rand_addr, busy, done, m_tvalid,
                    m_tlast, m_tdata, req_ready, rsp_valid, rsp_data};

  ring_reader #(.DATA_W(DW), .ADDR_W(AW), .RAND_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .ring_dout(ring_dout), .ring_ready(ring_ready),
    .ring_index(ring_index), .ring_rd_en(ring_rd_en), .ring_rand_addr(ring_rand_addr),
    .ring_rand_en(ring_rand_en), .ring_rand_valid(ring_rand_valid), .start(start),
    .burst_len(burst_len), .busy(busy), .done(done), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .req_addr(req_addr),
    .req_valid(req_valid), .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid)
  );

  // Ring model: front pointer pops on rd_en; random reads answer two cycles
  // after the request unless that request number equals drop_idx.
  logic [DW-1:0] mem [0:127];
  logic [AW-1:0] ptr = '0;
  logic [AW-1:0] rand_lat = '0;
  int rv_delay = 0, rand_total = 0, drop_idx = -1;

  assign ring_dout  = ring_rand_valid ? mem[rand_lat] : mem[ptr];
  assign ring_index = ptr;

  always @(posedge clk) begin
    if (rst) begin
      ptr <= '0; rv_delay <= 0; ring_rand_valid <= 1'b0;
    end else begin
      if (ring_rd_en) ptr <= ptr + 1'b1;
      ring_rand_valid <= (rv_delay == 1);
      if (rv_delay != 0) rv_delay <= rv_delay - 1;
      if (ring_rand_en) begin
        if (rand_total != drop_idx) begin rv_delay <= 2; rand_lat <= ring_rand_addr; end
        rand_total <= rand_total + 1;
      end
    end
  end

  // Monitor, sampled mid-cycle.
  int cyc = 0, rd_cnt = 0, rd_bad = 0, rand_cnt = 0, rsp_cnt = 0, done_cnt = 0, stall_err = 0;
  int rand_last = 0, rand_prev = 0;
  logic [AW-1:0]    rand_addr_seen = '0;
  logic [DW-1:0]    rsp_seen = '0;
  logic [AW+DW-1:0] beat_q[$];
  bit               last_q[$];
  logic             hold_v = 1'b0, hold_l = 1'b0;
  logic [AW+DW-1:0] hold_d = '0;

  always @(negedge clk) begin
    cyc++;
    if (ring_rd_en) rd_cnt++;
    if (ring_rd_en && !ring_ready) rd_bad++;
    if (ring_rand_en) begin
      rand_cnt++; rand_prev = rand_last; rand_last = cyc; rand_addr_seen = ring_rand_addr;
    end
    if (rsp_valid) begin rsp_cnt++; rsp_seen = rsp_data; end
    if (done) done_cnt++;
    if (m_tvalid && m_tready) begin beat_q.push_back(m_tdata); last_q.push_back(m_tlast); end
    if (hold_v && !rst && (!m_tvalid || m_tdata != hold_d || m_tlast != hold_l)) stall_err++;
    hold_v = m_tvalid && !m_tready && !rst;
    hold_d = m_tdata;
    hold_l = m_tlast;
  end

  int checks = 0, failures = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < 128; i++) mem[i] = base + DW'(i);
  endtask

  task automatic do_start(input logic [7:0] bl);
    burst_len = bl; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_req(input logic [AW-1:0] a, output bit ok);
    req_addr = a; req_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); ok = req_ready; @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // sel: 0 done pulses, 1 accepted beats, 2 responses, 3 random requests
  task automatic wait_until(input int sel, input int target, input int bound, output bit ok);
    int v;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      case (sel)
        0: v = done_cnt;
        1: v = beat_q.size();
        2: v = rsp_cnt;
        default: v = rand_cnt;
      endcase
      if (v >= target) ok = 1'b1; else tick();
    end
  endtask

  // Number of beats from n0 on that differ from {p0+k, mem[p0+k]} / tlast on last.
  function automatic int seq_errs(input int n0, input logic [AW-1:0] p0, input int n);
    int e = 0;
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] idx;
      idx = p0 + AW'(k);
      if (n0 + k >= beat_q.size()) e++;
      else begin
        if (beat_q[n0+k] !== {idx, mem[idx]}) e++;
        if (last_q[n0+k] !== (k == n - 1)) e++;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick();
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    rst = 1'b0; tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int n0, d0, r0; logic [AW-1:0] p0; bit ok;
    fill('0); m_tready = 1'b1; ring_ready = 1'b1;
    n0 = beat_q.size(); p0 = ptr; d0 = done_cnt; r0 = rd_cnt;
    do_start(8'd4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_until(0, d0 + 1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    tick(); tick();
    checks++; if (beat_q.size() - n0 !== 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", beat_q.size() - n0); end
    checks++; if (seq_errs(n0, p0, 4) !== 0) begin failures++; $display("FAIL basic_seq got=%0d exp=0", seq_errs(n0, p0, 4)); end
    checks++; if (rd_cnt - r0 !== 4) begin failures++; $display("FAIL basic_rd_en got=%0d exp=4", rd_cnt - r0); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_len0();
    int n0, d0; logic [AW-1:0] p0; bit ok;
    fill(14'h2000);
    n0 = beat_q.size(); p0 = ptr; d0 = done_cnt;
    do_start(8'd0);
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      m_tready = ~i[0]; tick(); ok = (done_cnt > d0);
    end
    m_tready = 1'b1; tick();
    checks++; if (!ok) begin failures++; $display("FAIL len0_timeout got=0 exp=1"); end
    checks++; if (beat_q.size() - n0 !== 128) begin failures++; $display("FAIL len0_count got=%0d exp=128", beat_q.size() - n0); end
    checks++; if (seq_errs(n0, p0, 128) !== 0) begin failures++; $display("FAIL len0_seq got=%0d exp=0", seq_errs(n0, p0, 128)); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL len0_stall_stable got=%0d exp=0", stall_err); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL len0_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_rand_mid();
    int n0, d0, q0, s0; logic [AW-1:0] p0; bit ok;
    fill(14'h1000); m_tready = 1'b1;
    n0 = beat_q.size(); p0 = ptr; d0 = done_cnt; q0 = rand_cnt; s0 = rsp_cnt;
    do_start(8'd8);
    wait_until(1, n0 + 3, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_beats_timeout got=0 exp=1"); end
    m_tready = 1'b0;
    do_req(7'h05, ok);
    m_tready = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL mid_req_accept got=0 exp=1"); end
    wait_until(2, s0 + 1, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_rsp_timeout got=0 exp=1"); end
    checks++; if (rsp_seen !== 14'h1005) begin failures++; $display("FAIL mid_rsp_data got=%h exp=1005", rsp_seen); end
    checks++; if (rand_addr_seen !== 7'h05) begin failures++; $display("FAIL mid_rand_addr got=%h exp=05", rand_addr_seen); end
    wait_until(0, d0 + 1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_done_timeout got=0 exp=1"); end
    tick(); tick();
    checks++; if (rand_cnt - q0 !== 1) begin failures++; $display("FAIL mid_rand_en_count got=%0d exp=1", rand_cnt - q0); end
    checks++; if (rsp_cnt - s0 !== 1) begin failures++; $display("FAIL mid_rsp_count got=%0d exp=1", rsp_cnt - s0); end
    checks++; if (seq_errs(n0, p0, 8) !== 0 || beat_q.size() - n0 !== 8) begin
      failures++; $display("FAIL mid_seq got=%0d beats errs=%0d exp=8 beats errs=0", beat_q.size() - n0, seq_errs(n0, p0, 8));
    end
  endtask

  task automatic test_rand_retry();
    int q0, s0; bit ok;
    drop_idx = rand_total; q0 = rand_cnt; s0 = rsp_cnt;
    do_req(7'h0A, ok);
    checks++; if (!ok) begin failures++; $display("FAIL retry_req_accept got=0 exp=1"); end
    wait_until(2, s0 + 1, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL retry_rsp_timeout got=0 exp=1"); end
    tick(); tick(); tick();
    checks++; if (rand_cnt - q0 !== 2) begin failures++; $display("FAIL retry_rand_en_count got=%0d exp=2", rand_cnt - q0); end
    checks++; if (rand_last - rand_prev !== 7) begin failures++; $display("FAIL retry_gap got=%0d exp=7", rand_last - rand_prev); end
    checks++; if (rsp_cnt - s0 !== 1) begin failures++; $display("FAIL retry_rsp_count got=%0d exp=1", rsp_cnt - s0); end
    checks++; if (rsp_seen !== 14'h100A) begin failures++; $display("FAIL retry_rsp_data got=%h exp=100a", rsp_seen); end
  endtask

  task automatic test_gap();
    int n0, d0, r1, b0; logic [AW-1:0] p0; bit ok;
    fill(14'h0300); m_tready = 1'b1; ring_ready = 1'b1;
    n0 = beat_q.size(); p0 = ptr; d0 = done_cnt; b0 = rd_bad;
    do_start(8'd6);
    wait_until(1, n0 + 2, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gap_beats_timeout got=0 exp=1"); end
    ring_ready = 1'b0; r1 = rd_cnt;
    repeat (10) tick();
    checks++; if (rd_cnt !== r1) begin failures++; $display("FAIL gap_no_rd got=%0d exp=%0d", rd_cnt, r1); end
    ring_ready = 1'b1;
    wait_until(0, d0 + 1, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gap_done_timeout got=0 exp=1"); end
    tick(); tick();
    checks++; if (rd_bad !== b0) begin failures++; $display("FAIL gap_rd_not_ready got=%0d exp=%0d", rd_bad, b0); end
    checks++; if (seq_errs(n0, p0, 6) !== 0 || beat_q.size() - n0 !== 6) begin
      failures++; $display("FAIL gap_seq got=%0d beats errs=%0d exp=6 beats errs=0", beat_q.size() - n0, seq_errs(n0, p0, 6));
    end
  endtask

  task automatic test_reset_mid();
    int n0, d0, q0, s0; logic [AW-1:0] p0; bit ok;
    fill(14'h0500); m_tready = 1'b1; ring_ready = 1'b1;
    n0 = beat_q.size();
    do_start(8'd8);
    wait_until(1, n0 + 3, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstb_beats_timeout got=0 exp=1"); end
    rst = 1'b1; tick();
    checks++; if (all_out !== '0) begin failures++; $display("FAIL rst_mid_burst got=%h exp=0", all_out); end
    rst = 1'b0; tick();
    checks++; if ({busy, m_tvalid} !== 2'b00) begin failures++; $display("FAIL rst_burst_idle got=%b exp=00", {busy, m_tvalid}); end
    drop_idx = rand_total; q0 = rand_cnt; s0 = rsp_cnt;
    do_req(7'h07, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstw_req_accept got=0 exp=1"); end
    wait_until(3, q0 + 1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstw_rand_timeout got=0 exp=1"); end
    tick(); tick();
    rst = 1'b1; tick();
    checks++; if (all_out !== '0) begin failures++; $display("FAIL rst_mid_rand got=%h exp=0", all_out); end
    rst = 1'b0; repeat (15) tick();
    checks++; if (rand_cnt - q0 !== 1) begin failures++; $display("FAIL rst_rand_cleared got=%0d exp=1", rand_cnt - q0); end
    checks++; if (rsp_cnt !== s0) begin failures++; $display("FAIL rst_no_rsp got=%0d exp=%0d", rsp_cnt, s0); end
    n0 = beat_q.size(); p0 = ptr; d0 = done_cnt;
    do_start(8'd2);
    wait_until(0, d0 + 1, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_restart_timeout got=0 exp=1"); end
    tick();
    checks++; if (seq_errs(n0, p0, 2) !== 0 || beat_q.size() - n0 !== 2) begin
      failures++; $display("FAIL rst_restart_seq got=%0d beats errs=%0d exp=2 beats errs=0", beat_q.size() - n0, seq_errs(n0, p0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    start = 1'b0; burst_len = 8'd0; m_tready = 1'b0; ring_ready = 1'b1;
    req_addr = '0; req_valid = 1'b0;
    fill('0);
    test_reset();
    test_basic();
    test_len0();
    test_rand_mid();
    test_rand_retry();
    test_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
